// File: rtl/hs_mon_pkg.sv
// hs_mon_pkg: shared types and helpers for the handshake protocol monitor.
//   hs_state_e    - per-channel 4-phase handshake state
//   ERR_*         - bit positions of the three error classes
//   popcount_sat  - count + popcount(done), saturated to an N-bit all-ones value
package hs_mon_pkg;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_ACK  = 2'd2,
        HS_REL  = 2'd3
    } hs_state_e;

    localparam int unsigned ERR_PROTO   = 0;
    localparam int unsigned ERR_TIMEOUT = 1;
    localparam int unsigned ERR_DATA    = 2;

    // Operands are zero-extended to 32 bits by the caller; the extra result
    // bit keeps the unsaturated sum from wrapping before the clamp.
    function automatic logic [32:0] popcount_sat(input logic [31:0]  count,
                                                 input logic [31:0]  done,
                                                 input int unsigned  cnt_w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, count};
        max_val = (33'd1 << cnt_w) - 33'd1;
        for (int unsigned i = 0; i < 32; i++) begin
            sum = sum + {32'd0, done[i]};
        end
        if (sum > max_val) begin
            sum = max_val;
        end
        return sum;
    endfunction

endpackage

// File: rtl/hs_channel_fsm.sv
// hs_channel_fsm: protocol tracker for one req/ack handshake channel.
//   Inputs : clk, rst_n (async, active low), req, ack, data_valid, data,
//            clr_err (sync clear of sticky flags)
//   Outputs: busy (registered, state != HS_IDLE), err_proto / err_timeout /
//            err_data (sticky, registered), done (combinational pulse on the
//            HS_REL -> HS_IDLE edge, summed by the top level)
// Optional: HS_MON_DEFERRED_ASSERT_EN adds deferred assertions and a cover.
module hs_channel_fsm
    import hs_mon_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              ack,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              clr_err,
    output logic              busy,
    output logic              err_proto,
    output logic              err_timeout,
    output logic              err_data,
    output logic              done
);

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    hs_state_e         state_q, state_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              busy_q, busy_d;
    logic [2:0]        err_q, err_d;
    logic [2:0]        err_new;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cap_d      = cap_q;
        err_new    = '0;
        done       = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (req && !ack) begin
                    state_d    = HS_REQ;
                    cap_d      = data;
                    wait_cnt_d = '0;
                end else if (ack) begin
                    err_new[ERR_PROTO] = 1'b1;
                    if (req) begin
                        state_d = HS_ACK;
                    end
                end
            end
            HS_REQ: begin
                if (!data_valid || (data != cap_q)) begin
                    err_new[ERR_DATA] = 1'b1;
                end
                if (ack) begin
                    state_d = HS_ACK;
                end else if (!req) begin
                    err_new[ERR_PROTO] = 1'b1;
                    state_d            = HS_IDLE;
                end else if (wait_cnt_q < TMO) begin
                    // Counter stops at TIMEOUT so the flag is raised once.
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_d == TMO) begin
                        err_new[ERR_TIMEOUT] = 1'b1;
                    end
                end
            end
            HS_ACK: begin
                if (!req) begin
                    state_d = HS_REL;
                end else if (!ack) begin
                    err_new[ERR_PROTO] = 1'b1;
                end
            end
            HS_REL: begin
                if (!ack) begin
                    state_d = HS_IDLE;
                    done    = 1'b1;
                end else if (req) begin
                    err_new[ERR_PROTO] = 1'b1;
                end
            end
            default: state_d = HS_IDLE;
        endcase
        busy_d = (state_d != HS_IDLE);
        // A fresh error beats a coincident clear.
        err_d  = err_new | (err_q & {3{~clr_err}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HS_IDLE;
            wait_cnt_q <= '0;
            cap_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cap_q      <= cap_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign busy        = busy_q;
    assign err_proto   = err_q[ERR_PROTO];
    assign err_timeout = err_q[ERR_TIMEOUT];
    assign err_data    = err_q[ERR_DATA];

`ifdef HS_MON_DEFERRED_ASSERT_EN
    always_comb begin
        a_ch_proto:    assert final (err_new == 3'b000);
        a_ch_spurious: assert #0 (!(req && !busy_q && ack));
        c_ch_done:     cover #0 (done);
    end
`else
`endif

endmodule

// File: rtl/hs_protocol_monitor.sv
// hs_protocol_monitor: multi-channel checker for 4-phase req/ack handshakes.
//   Inputs : clk, rst_n (async, active low), req/ack/data_valid [NUM_CH],
//            data [NUM_CH*DATA_W] (channel i at [i*DATA_W +: DATA_W]), clr_err
//   Outputs: busy, err_proto, err_timeout, err_data [NUM_CH];
//            xfer_count [CNT_W] saturating count of completed handshakes
// Limits : NUM_CH <= 32, CNT_W <= 32, TIMEOUT 1..65535.
// Optional: HS_MON_DEFERRED_ASSERT_EN enables per-channel deferred assertions.
module hs_protocol_monitor
    import hs_mon_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        ack,
    input  logic [NUM_CH-1:0]        data_valid,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic                     clr_err,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        err_proto,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic [NUM_CH-1:0]        err_data,
    output logic [CNT_W-1:0]         xfer_count
);

    logic [NUM_CH-1:0] done;
    logic [CNT_W-1:0]  xfer_count_q, xfer_count_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hs_channel_fsm #(
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (req[g]),
            .ack         (ack[g]),
            .data_valid  (data_valid[g]),
            .data        (data[g*DATA_W +: DATA_W]),
            .clr_err     (clr_err),
            .busy        (busy[g]),
            .err_proto   (err_proto[g]),
            .err_timeout (err_timeout[g]),
            .err_data    (err_data[g]),
            .done        (done[g])
        );
    end

    always_comb begin
        xfer_count_d = CNT_W'(popcount_sat(32'(xfer_count_q), 32'(done), CNT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_hs_protocol_monitor.sv
module tb_hs_protocol_monitor;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, ack, dv;
    logic [31:0] data;
    logic        clr_err;
    logic [3:0]  busy, err_proto, err_timeout, err_data;
    logic [15:0] xfer_count;

    // Second instance with a 4-bit counter so saturation is reachable quickly.
    logic [3:0]  req2, ack2, dv2;
    logic [31:0] data2;
    logic [3:0]  busy2, err_proto2, err_timeout2, err_data2;
    logic [3:0]  xfer_count2;

    int checks = 0;
    int errors = 0;

    hs_protocol_monitor #(
        .NUM_CH (4), .DATA_W (8), .TIMEOUT (16), .CNT_W (16)
    ) dut (
        .clk (clk), .rst_n (rst_n), .req (req), .ack (ack), .data_valid (dv),
        .data (data), .clr_err (clr_err), .busy (busy), .err_proto (err_proto),
        .err_timeout (err_timeout), .err_data (err_data), .xfer_count (xfer_count)
    );

    hs_protocol_monitor #(
        .NUM_CH (4), .DATA_W (8), .TIMEOUT (16), .CNT_W (4)
    ) dut_sat (
        .clk (clk), .rst_n (rst_n), .req (req2), .ack (ack2), .data_valid (dv2),
        .data (data2), .clr_err (clr_err), .busy (busy2), .err_proto (err_proto2),
        .err_timeout (err_timeout2), .err_data (err_data2), .xfer_count (xfer_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = '0; ack = '0; dv = '0; data = '0; clr_err = 1'b0;
        req2 = '0; ack2 = '0; dv2 = '0; data2 = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, err_proto, err_timeout, err_data, xfer_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, err_proto, err_timeout, err_data, xfer_count});
        end
        checks++;
        if (xfer_count2 !== 4'h0) begin
            errors++;
            $display("FAIL reset_count2: got %h expected 0", xfer_count2);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean_handshake();
        data[7:0] = 8'h5A; dv[0] = 1'b1;
        req[0] = 1'b1;
        step();
        checks++;
        if (busy !== 4'b0001) begin
            errors++; $display("FAIL clean_busy_req: got %b expected 0001", busy);
        end
        step();
        ack[0] = 1'b1; step();
        req[0] = 1'b0; step();
        checks++;
        if (busy !== 4'b0001 || xfer_count !== 16'd0) begin
            errors++;
            $display("FAIL clean_rel: busy %b cnt %0d expected 0001 cnt 0", busy, xfer_count);
        end
        ack[0] = 1'b0; step();
        checks++;
        if (busy !== 4'b0000 || xfer_count !== 16'd1) begin
            errors++;
            $display("FAIL clean_done: busy %b cnt %0d expected 0000 cnt 1", busy, xfer_count);
        end
        checks++;
        if ({err_proto, err_timeout, err_data} !== 12'h0) begin
            errors++;
            $display("FAIL clean_errs: got %h expected 000", {err_proto, err_timeout, err_data});
        end
    endtask

    task automatic test_timeout();
        data[15:8] = 8'h33; dv[1] = 1'b1;
        req[1] = 1'b1;
        step();                        // entry into HS_REQ
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (err_timeout !== 4'b0000) begin
            errors++; $display("FAIL timeout_early: got %b expected 0000", err_timeout);
        end
        step();
        checks++;
        if (err_timeout !== 4'b0010) begin
            errors++; $display("FAIL timeout_set: got %b expected 0010", err_timeout);
        end
        for (int i = 0; i < 5; i++) step();
        ack[1] = 1'b1; step();
        req[1] = 1'b0; step();
        ack[1] = 1'b0; step();
        checks++;
        if (xfer_count !== 16'd2 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_late_ack: cnt %0d busy %b expected cnt 2 busy 0000",
                     xfer_count, busy);
        end
        checks++;
        if (err_timeout !== 4'b0010 || err_proto !== 4'b0000 || err_data !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_flags: tmo %b proto %b data %b expected 0010 0000 0000",
                     err_timeout, err_proto, err_data);
        end
    endtask

    task automatic test_data_stability();
        data[23:16] = 8'h10; dv[2] = 1'b1;
        req[2] = 1'b1;
        step();
        step();
        checks++;
        if (err_data !== 4'b0000) begin
            errors++; $display("FAIL data_stable: got %b expected 0000", err_data);
        end
        data[23:16] = 8'h11;
        step();
        checks++;
        if (err_data !== 4'b0100) begin
            errors++; $display("FAIL data_change: got %b expected 0100", err_data);
        end
        data[23:16] = 8'h10;
        step();
        checks++;
        if (err_data !== 4'b0100) begin
            errors++; $display("FAIL data_sticky: got %b expected 0100", err_data);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (err_data !== 4'b0000 || err_timeout !== 4'b0000) begin
            errors++;
            $display("FAIL clr_err: data %b tmo %b expected 0000 0000", err_data, err_timeout);
        end
        clr_err = 1'b1; dv[2] = 1'b0;
        step();
        clr_err = 1'b0; dv[2] = 1'b1;
        checks++;
        if (err_data !== 4'b0100) begin
            errors++; $display("FAIL clr_vs_new: got %b expected 0100", err_data);
        end
        ack[2] = 1'b1; step();
        req[2] = 1'b0; step();
        ack[2] = 1'b0; step();
        checks++;
        if (xfer_count !== 16'd3 || err_proto !== 4'b0000) begin
            errors++;
            $display("FAIL data_done: cnt %0d proto %b expected 3 0000", xfer_count, err_proto);
        end
        clr_err = 1'b1; step(); clr_err = 1'b0;
    endtask

    task automatic test_spurious_ack();
        ack[3] = 1'b1;
        step();
        checks++;
        if (err_proto !== 4'b1000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL spurious_ack: proto %b busy %b expected 1000 0000", err_proto, busy);
        end
        ack[3] = 1'b0;
        step();
        checks++;
        if (busy !== 4'b0000 || err_proto !== 4'b1000 || xfer_count !== 16'd3) begin
            errors++;
            $display("FAIL spurious_idle: busy %b proto %b cnt %0d expected 0000 1000 3",
                     busy, err_proto, xfer_count);
        end
        clr_err = 1'b1; step(); clr_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        dv = 4'hF;
        req = 4'hF; step();
        ack = 4'hF; step();
        req = 4'h0; step();
        ack = 4'h0; step();
        checks++;
        if (xfer_count !== 16'd7 || busy !== 4'h0) begin
            errors++;
            $display("FAIL all_ch_done: cnt %0d busy %b expected 7 0000", xfer_count, busy);
        end
    endtask

    task automatic hs_sat(input logic [3:0] mask);
        dv2 = 4'hF;
        req2 = mask; step();
        ack2 = mask; step();
        req2 = 4'h0; step();
        ack2 = 4'h0; step();
    endtask

    task automatic test_saturation();
        hs_sat(4'hF); hs_sat(4'hF); hs_sat(4'hF);
        checks++;
        if (xfer_count2 !== 4'd12) begin
            errors++; $display("FAIL sat_pre12: got %0d expected 12", xfer_count2);
        end
        hs_sat(4'h1);
        checks++;
        if (xfer_count2 !== 4'd13) begin
            errors++; $display("FAIL sat_pre13: got %0d expected 13", xfer_count2);
        end
        hs_sat(4'hF);
        checks++;
        if (xfer_count2 !== 4'hF) begin
            errors++; $display("FAIL sat_clamp: got %0d expected 15", xfer_count2);
        end
        hs_sat(4'h3);
        checks++;
        if (xfer_count2 !== 4'hF || {err_proto2, err_timeout2, err_data2} !== 12'h0) begin
            errors++;
            $display("FAIL sat_hold: cnt %0d errs %h expected 15 000",
                     xfer_count2, {err_proto2, err_timeout2, err_data2});
        end
    endtask

    task automatic test_reset_mid_handshake();
        ack[3] = 1'b1; step(); ack[3] = 1'b0;   // leave a sticky flag set
        req[0] = 1'b1; step();
        ack[0] = 1'b1; step();
        checks++;
        if (busy !== 4'b0001 || err_proto !== 4'b1000) begin
            errors++;
            $display("FAIL pre_reset: busy %b proto %b expected 0001 1000", busy, err_proto);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, err_proto, err_timeout, err_data, xfer_count} !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {busy, err_proto, err_timeout, err_data, xfer_count});
        end
        req = '0; ack = '0;
        step();
        rst_n = 1'b1;
        step();
        req[0] = 1'b1; step();
        ack[0] = 1'b1; step();
        req[0] = 1'b0; step();
        ack[0] = 1'b0; step();
        checks++;
        if (xfer_count !== 16'd1 || busy !== 4'h0 ||
            {err_proto, err_timeout, err_data} !== 12'h0) begin
            errors++;
            $display("FAIL post_reset_hs: cnt %0d busy %b errs %h expected 1 0000 000",
                     xfer_count, busy, {err_proto, err_timeout, err_data});
        end
    endtask

    initial begin
        test_reset();
        test_clean_handshake();
        test_timeout();
        test_data_stability();
        test_spurious_ack();
        test_back_to_back();
        test_saturation();
        test_reset_mid_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
